// File: rtl/seg7_pkg.sv
// seg7_pkg: converter state type, active-high {g..a} digit patterns and the
// nibble decoder shared by the seven-segment display slice.
package seg7_pkg;

    typedef enum logic {IDLE, SHIFT} conv_state_e;

    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;

    function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_DASH;
        endcase
    endfunction

    // Elaboration-time helper for the digit-count sanity check.
    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

endpackage

// File: rtl/seg7_bin2bcd.sv
// seg7_bin2bcd: iterative double-dabble binary-to-BCD converter with a
// load/ready handshake; the result register updates only when a conversion completes.
module seg7_bin2bcd
    import seg7_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_W-1:0]     data,
    output logic                  ready,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int BCD_W = 4 * DIGITS;

    conv_state_e       state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [BCD_W-1:0]  acc_q, acc_d, acc_adj, bcd_q, bcd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
        end
    end

    assign last = cnt_q == CNT_W'(1);

    always_comb begin
        state_d = state_q == IDLE ? (load ? SHIFT : IDLE) : (last ? IDLE : SHIFT);
    end

    always_comb begin
        acc_adj = acc_q;
        for (int k = 0; k < DIGITS; k++)
            acc_adj[4*k +: 4] = acc_q[4*k +: 4] >= 4'd5 ? acc_q[4*k +: 4] + 4'd3 : acc_q[4*k +: 4];
        shreg_d = shreg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        if (state_q == IDLE && load) begin
            shreg_d = data;
            acc_d   = '0;
            cnt_d   = CNT_W'(DATA_W);
        end else if (state_q == SHIFT) begin
            {acc_d, shreg_d} = {acc_adj, shreg_q} << 1;
            cnt_d  = cnt_q - CNT_W'(1);
            done_d = last;
            bcd_d  = last ? acc_d : bcd_q;
        end
    end

    assign ready = state_q == IDLE;
    assign done  = done_q;
    assign bcd   = bcd_q;

endmodule

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: BCD conversion plus time-multiplexed seven-segment scan.
// Define SEG7_BLANK_EN to blank leading-zero digits (digit 0 is always shown).
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int DIGITS      = 3,
    parameter int REFRESH_DIV = 50000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_W-1:0]     data,
    output logic                  ready,
    output logic                  done,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [6:0]        SEG_RST = ACTIVE_LOW ? ~SEG_0 : SEG_0;
    localparam logic [DIGITS-1:0] AN_ONE  = DIGITS'(1);
    localparam logic [DIGITS-1:0] AN_RST  = ACTIVE_LOW ? ~AN_ONE : AN_ONE;

    if (DATA_W < 4 || DIGITS < 1 || REFRESH_DIV < 2 ||
        pow10(DIGITS) <= (64'd1 << DATA_W) - 64'd1) begin : g_bad_params
        $error("seg7_scan_display: invalid DATA_W/DIGITS/REFRESH_DIV combination");
    end

    seg7_bin2bcd #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .data  (data),
        .ready (ready),
        .done  (done),
        .bcd   (bcd)
    );

    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [6:0]        seg_q, seg_d, seg_hi;
    logic [DIGITS-1:0] an_q, an_d, an_hi;
    logic [3:0]        nib;
    logic              tc;
    logic              blank;

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
            idx_q <= '0;
            seg_q <= SEG_RST;
            an_q  <= AN_RST;
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign tc  = pre_q == PRE_W'(REFRESH_DIV - 1);
    assign nib = 4'(bcd >> {idx_q, 2'b00});

`ifdef SEG7_BLANK_EN
    logic [DIGITS-1:0] blank_vec;

    // Walk from the most significant digit down; a digit stays blank until a
    // nonzero nibble has been seen at or above it.
    always_comb begin
        logic seen;
        seen      = 1'b0;
        blank_vec = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            seen         = seen | (bcd[4*k +: 4] != 4'd0);
            blank_vec[k] = !seen && k != 0;
        end
    end

    assign blank = blank_vec[idx_q];
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        pre_d  = tc ? '0 : pre_q + PRE_W'(1);
        idx_d  = !tc ? idx_q : (idx_q == IDX_W'(DIGITS - 1) ? '0 : idx_q + IDX_W'(1));
        seg_hi = blank ? '0 : seg7_decode(nib);
        an_hi  = blank ? '0 : AN_ONE << idx_q;
        seg_d  = ACTIVE_LOW ? ~seg_hi : seg_hi;
        an_d   = ACTIVE_LOW ? ~an_hi : an_hi;
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: doc/seg7_scan_display.md
# seg7_scan_display

Parametrised multi-digit decimal display driver. Converts an unsigned binary value to BCD with an iterative shift-add-3 (double-dabble) engine and drives a time-multiplexed common-anode or common-cathode seven-segment bank from one shared segment bus. It sits between the ALU result register and the board display pins. It replaces per-digit static decoding with a load/ready handshake, configurable width and digit count, and a scan refresh counter.

## Interface
Parameters:
- DATA_W, 8, width of the binary input. Minimum 4.
- DIGITS, 3, number of decimal digits. Must satisfy 10^DIGITS > 2^DATA_W − 1; elaboration fails otherwise.
- REFRESH_DIV, 50000, clock cycles per digit slot. Minimum 2.
- ACTIVE_LOW, 1, 1 = segment and anode outputs are active-low; 0 = active-high.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- load  in  1  request to convert `data`
- data  in  DATA_W  unsigned binary value
- ready  out  1  converter idle; a load is accepted this cycle
- done  out  1  one-cycle pulse when the new value reaches the display registers
- seg  out  7  segment drive, bit order {g,f,e,d,c,b,a}
- an  out  DIGITS  digit enable, one-hot; bit 0 = ones digit
- bcd  out  4*DIGITS  displayed BCD value; nibble k = digit 10^k

## Operation
- Converter FSM: IDLE → SHIFT → IDLE.
  - IDLE: ready=1. `load && ready` latches `data` into the shift register, clears the BCD accumulator, sets the bit counter to DATA_W, and enters SHIFT.
  - SHIFT: ready=0. Each cycle, add 3 to every accumulator nibble ≥ 5, then shift {acc, shreg} left by 1 and decrement the counter.
  - After the DATA_W-th shift, write the accumulator to `bcd`, pulse done, and return to IDLE.
  - `load` while ready=0 is ignored. No queueing.
- `bcd` changes only on the done edge. The display never shows a partial result.
- Scanner (free-running, independent of the converter):
  - Prescaler counts 0..REFRESH_DIV−1.
  - At terminal count, the prescaler returns to 0 and digit index idx increments, wrapping DIGITS−1 → 0.
- Decode, in active-high {g..a} form: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  - Nibble values 10..15 decode to 1000000 (dash). They are unreachable in normal operation.
- seg and an are registered from idx and the selected `bcd` nibble.
- When ACTIVE_LOW=1, both seg and an are bit-inverted.
- Reset values:
  - Converter: IDLE, ready=1, done=0, bcd=0.
  - Scanner: prescaler=0, idx=0.
  - Outputs: seg = the "0" pattern (after polarity); an = digit 0 enabled (after polarity).
- Reset during SHIFT aborts the conversion. `bcd` returns to 0 and no done pulse is generated.

## Timing
- Accept edge T0. Shifts occur on edges T0+1..T0+DATA_W. done=1 and the new `bcd` are visible in the cycle after edge T0+DATA_W. ready=1 in that same cycle.
- Load-to-done latency: DATA_W cycles. Throughput: one conversion per DATA_W+1 cycles; a load asserted during the done cycle is accepted.
- `bcd` to seg/an: one register stage, ≤ 1 cycle after the edge that selects the digit.
- Digit slot length: exactly REFRESH_DIV cycles. Full frame: DIGITS·REFRESH_DIV cycles.
- An idx wrap on the same edge as a done pulse is legal. The next slot shows the new value.

## Configuration
- SEG7_BLANK_EN defined: leading-zero blanking.
  - Digit k>0 is blanked when nibbles k..DIGITS−1 are all zero. Blanked means seg all-off and the an bit inactive for that slot.
  - Digit 0 is never blanked.
  - The scan timing is unchanged.
- SEG7_BLANK_EN undefined: every digit is shown, leading zeros included.

## Structure
- Package seg7_pkg holds:
  - the converter state enum {IDLE, SHIFT};
  - the 7-bit digit pattern constants and the dash constant;
  - the function seg7_decode(nibble) returning the active-high pattern.
- Sub-module seg7_bin2bcd contains the handshake FSM, shift register, and add-3 logic. It is parametrised by DATA_W and DIGITS and outputs ready, done, and bcd.
- The top level instantiates seg7_bin2bcd and contains the prescaler, idx counter, blanking, decode, and output registers.

## Test plan
All scenarios use DATA_W=8, DIGITS=3, REFRESH_DIV=4, ACTIVE_LOW=1.
- Reset: hold rst for 3 cycles → ready=1, done=0, bcd=0x000, seg=~0111111, an=~3'b001.
- Load 8'd255 → ready low for 8 cycles; done pulses 8 cycles after the accept edge; bcd=0x255. The scan then shows "5", "5", "2" on an=~001, ~010, ~100, each for 4 cycles.
- Load 8'd200, then assert load with 8'd7 for the next 4 cycles → bcd=0x200. The second request is ignored.
- Back-to-back: load 8'd99, then load 8'd100 in the done cycle → bcd=0x099, then 0x100, with done pulses 9 cycles apart.
- Assert rst on the 4th SHIFT cycle of 8'd128 → bcd stays 0x000, no done pulse, ready=1 after reset.
- With SEG7_BLANK_EN, load 8'd7 → digits 1 and 2 have seg all-off and an inactive; digit 0 shows "7" (seg=~0000111). Without the macro, the display shows "007".
